// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline widths and constants for the fetch stage
package pipe_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus bundle
//   hazard/ID controls: stall, branch_taken/branch_target, jump/jump_target
//   imem: imem_addr out, imem_rdata in (combinational read)
//   IF/ID: if_id_instr, if_id_pc4, if_id_valid; perf: stall_cnt, flush_cnt
//   master = the fetch stage, slave = its environment
interface if_stage_if import pipe_pkg::*; #(parameter int CNT_W = 32);
  logic stall;
  logic branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic jump;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0] if_id_pc4;
  logic if_id_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    input stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, stall_cnt, flush_cnt
  );
  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
    input imem_addr, if_id_instr, if_id_pc4, if_id_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones, cleared by async reset
//   clk, rst_n (async active-low), inc (count this edge), count (value)
module sat_counter #(parameter int W = 32) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch, PC register, next-PC select and IF/ID register
//   clk, rst_n (async active-low); bus: if_stage_if.master carrying hazard/redirect
//   controls, imem address/data, IF/ID outputs and stall/flush perf counters
module if_stage import pipe_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  if_stage_if.master bus
);
  logic [ADDR_W-1:0] pc, pc_next4, tgt, id_pc4;
  logic [INSTR_W-1:0] id_instr;
  logic id_valid, redirect;
  assign pc_next4 = pc + 32'd4;
  assign redirect = bus.jump | bus.branch_taken;
  assign tgt = bus.jump ? bus.jump_target : bus.branch_target;
  // a stall freezes everything, including any redirect presented alongside it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_pc4 <= '0;
      id_valid <= 1'b0;
    end else if (!bus.stall) begin
      pc <= redirect ? {tgt[ADDR_W-1:2], 2'b00} : pc_next4;
      id_instr <= redirect ? NOP_INSTR : bus.imem_rdata;
      id_pc4 <= redirect ? '0 : pc_next4;
      id_valid <= !redirect;
    end
  assign bus.imem_addr = pc;
  assign bus.if_id_instr = id_instr;
  assign bus.if_id_pc4 = id_pc4;
  assign bus.if_id_valid = id_valid;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(bus.stall), .count(bus.stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(!bus.stall && redirect), .count(bus.flush_cnt)
  );
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, next-PC selection and the IF/ID pipeline register.
- Consumes `stall` from hazard detection and the resolved branch/jump redirect from ID.
- Produces the fetched instruction and PC+4 for the decode stage.
- Carries two saturating event counters (stall cycles, redirect flushes) for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and IF/ID this cycle (from hazard detection).
- branch_taken  in  1  ID resolved a taken beq/bne.
- branch_target  in  32  branch destination address.
- jump  in  1  ID decoded j/jal.
- jump_target  in  32  jump destination address.
- imem_addr  out  32  instruction memory address; equals current PC.
- imem_rdata  in  32  instruction word; combinational read, valid in the same cycle.
- if_id_instr  out  32  registered instruction to ID.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  if_id_instr holds a real fetched instruction.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.
- flush_cnt  out  CNT_W  saturating count of redirect flushes.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, also mid-operation):
  - pc = RESET_PC.
  - if_id_instr = NOP (32'h0000_0000), if_id_pc4 = 0, if_id_valid = 0.
  - Both counters = 0.
- imem_addr = pc, combinational.
- The first valid instruction appears on IF/ID one edge after reset release, provided stall is low.
- Per rising edge, priority highest first:
  1. stall = 1:
     - pc, if_id_instr, if_id_pc4, if_id_valid all hold.
     - stall_cnt += 1.
     - Any branch_taken or jump in the same cycle is ignored, since operands are unresolved during a hazard stall; ID re-presents it after the stall clears.
  2. jump = 1:
     - pc <= {jump_target[31:2], 2'b00}.
     - IF/ID <= NOP, if_id_pc4 <= 0, if_id_valid <= 0.
     - flush_cnt += 1.
  3. branch_taken = 1: same as (2) using branch_target. When jump and branch_taken are both high, jump wins and flush_cnt increments once.
  4. Otherwise:
     - pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
     - if_id_instr <= imem_rdata, if_id_pc4 <= pc + 4 (same wrap), if_id_valid <= 1.
- Target addresses: bits [1:0] are forced to 0; no misalignment error is raised.
- Counters:
  - Increment by exactly 1 per qualifying edge.
  - Saturate at 2^CNT_W - 1 and never wrap.
  - Cleared only by reset.
- No combinational path from stall, branch_taken or jump to any output. All outputs except imem_addr are registered.
- A one-cycle redirect delivers exactly one bubble. The wrong-path instruction fetched in the redirect cycle is discarded, never latched.

Decomposition:
- Shared package `pipe_pkg`:
  - ADDR_W = 32, INSTR_W = 32.
  - NOP_INSTR = 32'h0000_0000.
  - Default RESET_PC constant.
- One sub-module, `sat_counter` (params W; ports clk, rst_n, inc, count), instantiated twice for stall_cnt and flush_cnt.
- PC and IF/ID registers stay inline in if_stage.

Test Plan:
- Reset then release with stall = 0 and imem returning {pc}:
  - imem_addr = 0, 4, 8 on successive cycles.
  - if_id_instr/if_id_pc4 = (0, 4), (4, 8).
  - if_id_valid rises one edge after release.
- Stall held 3 cycles at pc = 0x10: pc and IF/ID frozen for 3 edges, stall_cnt = 3, flush_cnt = 0. Fetch resumes at 0x14 afterwards.
- branch_taken = 1, branch_target = 0x103 at pc = 0x20:
  - Next pc = 0x100; IF/ID = NOP with if_id_valid = 0 for one cycle; flush_cnt = 1.
  - Following cycle latches imem_rdata from 0x100 with if_id_pc4 = 0x104.
- stall = 1 together with branch_taken = 1: no redirect, pc holds, flush_cnt unchanged, stall_cnt + 1. Same cycle with jump = 1 and branch_taken = 1 (stall low): pc = jump_target, flush_cnt + 1 only.
- pc forced near top, fetch from 0xFFFF_FFFC: next pc = 0, if_id_pc4 = 0.
- CNT_W = 3 with 10 consecutive stall cycles: stall_cnt reads 7 and stays 7. rst_n pulsed low mid-stall clears all outputs immediately, without waiting for a clock edge.
